// File: rtl/e_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Multiplies take one cycle and divides take XLEN cycles (radix-2 restoring); the pipeline is stalled meanwhile.
module e_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [4:0]      rd_in,
  output logic            stall_req,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic [1:0]      dbg_state
);

  // Handshake: an op is taken on the edge where state is IDLE, valid_in=1 and flush=0.
  // The result is presented in the single DONE cycle, marked by result_valid.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nx;
  logic [CW-1:0]   counter;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rem_q, quo_q;
  logic            neg_quo_q, neg_rem_q;

  logic            accept, signed_in, div_zero, div_ovf;
  logic [XLEN-1:0] abs1, abs2, special_res;

  logic [XLEN:0]   shifted, trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

  logic signed [XLEN:0]     ma, mb;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN-1:0]          mul_res;

  assign accept    = (state == S_IDLE) && valid_in && !flush;
  assign signed_in = !md_op[0];
  assign div_zero  = (operand2 == '0);
  assign div_ovf   = signed_in && (operand1 == MIN_NEG) && (operand2 == '1);
  assign abs1      = (signed_in && operand1[XLEN-1]) ? -operand1 : operand1;
  assign abs2      = (signed_in && operand2[XLEN-1]) ? -operand2 : operand2;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = md_op[1] ? operand1 : '1;
    else          special_res = md_op[1] ? '0 : MIN_NEG;
  end

  // One restoring step: the dividend shifts out of quo_q while quotient bits shift in.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, b_q};
  assign q_bit   = !trial[XLEN];
  assign rem_nx  = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], q_bit};
  assign q_fix   = neg_quo_q ? -quo_nx : quo_nx;
  assign r_fix   = neg_rem_q ? -rem_nx : rem_nx;

  // MULHSU treats only operand1 as signed; MUL's low half is signedness-independent.
  assign ma      = {(op_q != 3'd3) & a_q[XLEN-1], a_q};
  assign mb      = {(op_q[1] == 1'b0) & b_q[XLEN-1], b_q};
  assign prod    = ma * mb;
  assign mul_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            if (!md_op[2])               state_nx = S_MUL;
            else if (div_zero || div_ovf) state_nx = S_DONE;
            else                          state_nx = S_DIV;
          end
        end
        S_MUL:  state_nx = S_DONE;
        S_DIV:  if (counter == CW'(XLEN-1)) state_nx = S_DONE;
        S_DONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      counter   <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q      <= md_op;
            rd_q      <= rd_in;
            counter   <= '0;
            a_q       <= operand1;
            b_q       <= md_op[2] ? abs2 : operand2;
            rem_q     <= '0;
            quo_q     <= abs1;
            neg_quo_q <= signed_in && (operand1[XLEN-1] ^ operand2[XLEN-1]);
            neg_rem_q <= signed_in && operand1[XLEN-1];
            if (md_op[2] && (div_zero || div_ovf)) begin
              result <= special_res;
              rd_out <= rd_in;
            end
          end
        end
        S_MUL: begin
          if (!flush) begin
            result <= mul_res;
            rd_out <= rd_q;
          end
        end
        S_DIV: begin
          if (!flush) begin
            counter <= counter + 1'b1;
            rem_q   <= rem_nx;
            quo_q   <= quo_nx;
            if (counter == CW'(XLEN-1)) begin
              result <= op_q[1] ? r_fix : q_fix;
              rd_out <= rd_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_req    = accept || (state == S_MUL) || (state == S_DIV);
  assign busy         = (state == S_MUL) || (state == S_DIV);
  assign result_valid = (state == S_DONE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_e_muldiv.sv
// Bench for e_muldiv: directed RV32M cases, flush/reset scenarios and random ops
// checked against an arithmetic reference model.
module tb_e_muldiv;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic [2:0]  md_op = '0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [4:0]  rd_in = '0;
  logic        stall_req, busy, result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  int passed = 0;
  int total = 0;

  e_muldiv #(.XLEN(32)) dut (
    .clk(clk), .nrst(nrst), .flush(flush), .valid_in(valid_in), .md_op(md_op),
    .operand1(operand1), .operand2(operand2), .rd_in(rd_in),
    .stall_req(stall_req), .busy(busy), .result_valid(result_valid),
    .result(result), .rd_out(rd_out), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    logic ovf;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 4) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int cyc;
    logic done, stall_bad;
    @(negedge clk);
    valid_in = 1'b1; md_op = op; operand1 = a; operand2 = b; rd_in = rd;
    #1 check({tag, "_stall_T"}, 32'(stall_req), 32'd1);
    cyc = 0; done = 1'b0; stall_bad = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (result_valid) done = 1'b1;
      else if (stall_req !== 1'b1) stall_bad = 1'b1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(model_lat(op, a, b)));
    check({tag, "_result"}, result, model(op, a, b));
    check({tag, "_rd_out"}, 32'(rd_out), 32'(rd));
    check({tag, "_stall_done"}, 32'(stall_req), 32'd0);
    check({tag, "_stall_hold"}, 32'(stall_bad), 32'd0);
    valid_in = 1'b0;
  endtask

  initial begin
    int seen;
    logic [31:0] last;
    #1;
    check("rst_result", result, 32'h0);
    check("rst_rd_out", 32'(rd_out), 32'h0);
    check("rst_valid", 32'(result_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stall", 32'(stall_req), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    last = result;
    @(negedge clk);
    check("result_hold", result, last);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd11);
    run_op("divu_z", 3'd5, 32'd5, 32'd0, 5'd12);
    run_op("remu_z", 3'd7, 32'd5, 32'd0, 5'd13);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    run_op("div_z", 3'd4, 32'hFFFF_FF00, 32'd0, 5'd16);
    run_op("divu_big", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);

    // Flush a divide mid-flight.
    @(negedge clk);
    valid_in = 1'b1; md_op = 3'd4; operand1 = 32'd1000; operand2 = 32'd3; rd_in = 5'd20;
    repeat (10) @(negedge clk);
    flush = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_state", 32'(dbg_state), 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (result_valid) seen++; end
    check("flush_no_valid", 32'(seen), 32'd0);

    // Flush while an op is offered in IDLE.
    @(negedge clk);
    valid_in = 1'b1; flush = 1'b1; md_op = 3'd0; operand1 = 32'd3; operand2 = 32'd3;
    #1 check("flush_idle_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (3) begin @(negedge clk); if (result_valid) seen++; end
    check("flush_idle_no_valid", 32'(seen), 32'd0);

    // Back-to-back divides.
    run_op("b2b_a", 3'd5, 32'd1234567, 32'd89, 5'd21);
    run_op("b2b_b", 3'd7, 32'd1234567, 32'd89, 5'd22);

    // Asynchronous reset during a divide.
    @(negedge clk);
    valid_in = 1'b1; md_op = 3'd5; operand1 = 32'd99; operand2 = 32'd4; rd_in = 5'd23;
    repeat (5) @(negedge clk);
    #2 nrst = 1'b0; valid_in = 1'b0;
    #1;
    check("arst_result", result, 32'h0);
    check("arst_rd_out", 32'(rd_out), 32'h0);
    check("arst_valid", 32'(result_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_stall", 32'(stall_req), 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    repeat (35) begin @(negedge clk); if (result_valid) seen++; end
    check("arst_no_valid", 32'(seen), 32'd0);
    run_op("post_rst_mul", 3'd0, 32'd12345, 32'd678, 5'd24);

    for (int i = 0; i < 30; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick(),
             5'($urandom_range(1, 31)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
